bunch_strobe_seq: RTL

BUNCH_STROBE_SEQ -- requirements
Module: bunch_strobe_seq

---
 rtl/bunch_strobe_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bunch_strobe_seq.sv
// rtl/bunch_strobe_seq.sv - bunch strobe sequencer driving an I/Q integrator
// Optional feature: define BUNCH_STROBE_TRIG_SYNC_EN to add a two-flop trig synchronizer.
`timescale 1ns/1ps
module bunch_strobe_seq #(
  parameter int DLY_W = 8,
  parameter int WID_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [DLY_W-1:0] start_dly,
  input  logic [WID_W-1:0] strb_width,
  input  logic [DLY_W-1:0] gap_len,
  input  logic [1:0]       n_bunch,
  output logic             bunch_strb,
  output logic             dac_cond,
  output logic [1:0]       bunch_idx,
  output logic             int_valid,
  output logic             busy,
  output logic             trig_missed
);

  localparam int CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx_n;
  logic [WID_W-1:0] wid_l, wid_n;
  logic [DLY_W-1:0] gap_l, gap_n;
  logic [1:0]       nb_l, nb_n;
  logic             trig_in;
  logic             trig_d;
  logic             trig_edge;

`ifdef BUNCH_STROBE_TRIG_SYNC_EN
  logic trig_s1, trig_s2;

  // Two-flop synchronizer; preset high so a trig held across reset is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1 <= 1'b1;
      trig_s2 <= 1'b1;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
    end
  end

  assign trig_in = trig_s2;
`else
  assign trig_in = trig;
`endif

  // Edge-detect history; preset high so a trig held high through reset release never starts a sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_d <= 1'b1;
    else     trig_d <= trig_in;
  end

  assign trig_edge = trig_in & ~trig_d;

  // Next-state, counter and bunch-index logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bunch_idx;
    wid_n   = wid_l;
    gap_n   = gap_l;
    nb_n    = nb_l;
    case (state)
      S_IDLE: begin
        if (trig_edge) begin
          wid_n = (strb_width == '0) ? WID_W'(1) : strb_width;
          gap_n = (gap_len == '0) ? DLY_W'(1) : gap_len;
          nb_n  = n_bunch;
          idx_n = 2'd0;
          if (start_dly == '0) begin
            state_n = S_STROBE;
            cnt_n   = CNT_W'(wid_n) - CNT_W'(1);
          end else begin
            state_n = S_DELAY;
            cnt_n   = CNT_W'(start_dly) - CNT_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (cnt == '0) begin
          state_n = S_STROBE;
          cnt_n   = CNT_W'(wid_l) - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          if (bunch_idx < nb_l) begin
            state_n = S_GAP;
            cnt_n   = CNT_W'(gap_l) - CNT_W'(1);
          end else begin
            state_n = S_SETTLE;
            cnt_n   = CNT_W'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_STROBE;
          idx_n   = bunch_idx + 2'd1;
          cnt_n   = CNT_W'(wid_l) - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_CLEAR: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and latched sequence parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bunch_idx <= 2'd0;
      wid_l     <= '0;
      gap_l     <= '0;
      nb_l      <= 2'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bunch_idx <= idx_n;
      wid_l     <= wid_n;
      gap_l     <= gap_n;
      nb_l      <= nb_n;
    end
  end

  // Registered outputs decoded from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bunch_strb  <= 1'b0;
      dac_cond    <= 1'b0;
      int_valid   <= 1'b0;
      busy        <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      bunch_strb  <= (state_n == S_STROBE);
      dac_cond    <= (state_n == S_CLEAR);
      int_valid   <= (state_n == S_SETTLE) && (cnt_n == '0);
      busy        <= (state_n != S_IDLE);
      trig_missed <= trig_edge && (state != S_IDLE);
    end
  end

endmodule
